// File: rtl/psram_qpi_pkg.sv
// Shared opcodes, address width and FSM encoding for the QPI PSRAM responder.
package psram_qpi_pkg;

  localparam int ADDR_W = 23;

  localparam logic [7:0] CMD_RSTEN    = 8'h66;
  localparam logic [7:0] CMD_RST      = 8'h99;
  localparam logic [7:0] CMD_SPI2QPI  = 8'h35;
  localparam logic [7:0] CMD_QPI_EXIT = 8'hF5;
  localparam logic [7:0] CMD_READ     = 8'hEB;
  localparam logic [7:0] CMD_WRITE    = 8'h38;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SPI_CMD = 3'd1,
    QPI_CMD = 3'd2,
    ADDR    = 3'd3,
    WR_DATA = 3'd4,
    RD_WAIT = 3'd5,
    RD_DATA = 3'd6,
    IGNORE  = 3'd7
  } state_e;

endpackage

// File: rtl/psram_qpi_resp_mem.sv
// Dual-port word array: port A read/write for the protocol FSM, port B read-only backdoor.
module psram_qpi_resp_mem #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [DEPTH_LOG2-1:0] a_addr,
  input  logic [15:0]           a_wdata,
  output logic [15:0]           a_rdata,
  input  logic [DEPTH_LOG2-1:0] b_addr,
  output logic [15:0]           b_rdata
);

  logic [15:0] mem_q [2**DEPTH_LOG2];
  logic [15:0] a_rdata_q;
  logic [15:0] b_rdata_q;

  // Port A holds its last read word while disabled, so a prefetch stays valid.
  always_ff @(posedge clk) begin
    if (a_en) begin
      if (a_we) mem_q[a_addr] <= a_wdata;
      a_rdata_q <= mem_q[a_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) b_rdata_q <= '0;
    else        b_rdata_q <= mem_q[b_addr];
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/psram_qpi_responder.sv
// LY68L6400-style SPI/QPI PSRAM device model on block RAM. Bus is sampled on
// posedge of mem_clk; read nibbles launch on negedge and are gated off when CE rises.
module psram_qpi_responder
  import psram_qpi_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int READ_WAIT  = 6
) (
  input  logic                  mem_clk,
  input  logic                  rst_n,
  input  logic                  mem_ce,
  input  logic [3:0]            sio_in,
  output logic [3:0]            sio_out,
  output logic                  sio_oe,
  output logic                  qpi_mode,
  output logic                  cmd_err,
  input  logic [DEPTH_LOG2-1:0] dbg_addr,
  output logic [15:0]           dbg_data
);

  localparam int CNT_W = 8;

  state_e                state_q, state_d;
  logic [7:0]            op_q, op_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DEPTH_LOG2-1:0] widx_q, widx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            nib_q, nib_d;
  logic [11:0]           wdata_q, wdata_d;
  logic [15:0]           rd_word_q, rd_word_d;
  logic                  qpi_q, qpi_d;
  logic                  err_q, err_d;
  logic                  armed_q, armed_d;
  logic [3:0]            sio_out_q, sio_out_d;
  logic                  oe_q, oe_d;

  logic [7:0]            op_spi, op_qpi, cmd;
  logic [ADDR_W-1:0]     addr_full;
  logic [DEPTH_LOG2-1:0] addr_idx;
  logic                  decode_now;
  logic                  mem_en, mem_we;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [15:0]           mem_wdata, mem_rdata;

  psram_qpi_resp_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk     (mem_clk),
    .rst_n   (rst_n),
    .a_en    (mem_en),
    .a_we    (mem_we),
    .a_addr  (mem_addr),
    .a_wdata (mem_wdata),
    .a_rdata (mem_rdata),
    .b_addr  (dbg_addr),
    .b_rdata (dbg_data)
  );

  always_comb begin
    op_spi     = {op_q[6:0], sio_in[0]};
    op_qpi     = {op_q[3:0], sio_in};
    cmd        = qpi_q ? op_qpi : op_spi;
    addr_full  = ADDR_W'({addr_q, sio_in});
    addr_idx   = DEPTH_LOG2'(addr_full);
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    widx_d     = widx_q;
    cnt_d      = cnt_q;
    nib_d      = nib_q;
    wdata_d    = wdata_q;
    rd_word_d  = rd_word_q;
    qpi_d      = qpi_q;
    err_d      = err_q;
    armed_d    = armed_q;
    decode_now = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = widx_q;
    mem_wdata  = {wdata_q, sio_in};

    if (mem_ce) begin
      state_d = IDLE;
      cnt_d   = '0;
      nib_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          op_d    = qpi_q ? op_qpi : op_spi;
          cnt_d   = CNT_W'(1);
          state_d = qpi_q ? QPI_CMD : SPI_CMD;
        end
        SPI_CMD: begin
          op_d       = op_spi;
          cnt_d      = cnt_q + 1'b1;
          decode_now = (cnt_q == CNT_W'(7));
        end
        QPI_CMD: begin
          op_d       = op_qpi;
          decode_now = 1'b1;
        end
        ADDR: begin
          addr_d = addr_full;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(5)) begin
            widx_d = addr_idx;
            cnt_d  = '0;
            nib_d  = '0;
            if (op_q == CMD_READ) begin
              mem_en   = 1'b1;
              mem_addr = addr_idx;
              state_d  = RD_WAIT;
            end else begin
              state_d  = WR_DATA;
            end
          end
        end
        WR_DATA: begin
          wdata_d = {wdata_q[7:0], sio_in};
          nib_d   = nib_q + 1'b1;
          if (nib_q == 2'd3) begin
            mem_en = 1'b1;
            mem_we = 1'b1;
            widx_d = widx_q + 1'b1;
          end
        end
        RD_WAIT: begin
          cnt_d = cnt_q + 1'b1;
          // Take the word fetched at k=7 and prefetch the next so bursts stream gap-free.
          if (cnt_q == CNT_W'(READ_WAIT - 1)) begin
            rd_word_d = mem_rdata;
            nib_d     = '0;
            mem_en    = 1'b1;
            mem_addr  = widx_q + 1'b1;
            widx_d    = widx_q + 1'b1;
            state_d   = RD_DATA;
          end
        end
        RD_DATA: begin
          nib_d = nib_q + 1'b1;
          if (nib_q == 2'd3) begin
            rd_word_d = mem_rdata;
            mem_en    = 1'b1;
            mem_addr  = widx_q + 1'b1;
            widx_d    = widx_q + 1'b1;
          end
        end
        IGNORE: ;
        default: state_d = IDLE;
      endcase

      if (decode_now) begin
        state_d = IGNORE;
        armed_d = 1'b0;
        cnt_d   = '0;
        case (cmd)
          CMD_RSTEN:          armed_d = 1'b1;
          CMD_RST:            if (armed_q) begin err_d = 1'b0; qpi_d = 1'b0; end
          CMD_SPI2QPI:        if (qpi_q) err_d = 1'b1; else qpi_d = 1'b1;
          CMD_QPI_EXIT:       if (qpi_q) qpi_d = 1'b0; else err_d = 1'b1;
          CMD_READ, CMD_WRITE: if (qpi_q) state_d = ADDR; else err_d = 1'b1;
          default:            err_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      widx_q    <= '0;
      cnt_q     <= '0;
      nib_q     <= '0;
      wdata_q   <= '0;
      rd_word_q <= '0;
      qpi_q     <= 1'b0;
      err_q     <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      widx_q    <= widx_d;
      cnt_q     <= cnt_d;
      nib_q     <= nib_d;
      wdata_q   <= wdata_d;
      rd_word_q <= rd_word_d;
      qpi_q     <= qpi_d;
      err_q     <= err_d;
      armed_q   <= armed_d;
    end
  end

  always_comb begin
    sio_out_d = sio_out_q;
    oe_d      = (state_q == RD_DATA);
    if (state_q == RD_DATA) begin
      case (nib_q)
        2'd0:    sio_out_d = rd_word_q[15:12];
        2'd1:    sio_out_d = rd_word_q[11:8];
        2'd2:    sio_out_d = rd_word_q[7:4];
        default: sio_out_d = rd_word_q[3:0];
      endcase
    end
  end

  always_ff @(negedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      sio_out_q <= '0;
      oe_q      <= 1'b0;
    end else begin
      sio_out_q <= sio_out_d;
      oe_q      <= oe_d;
    end
  end

  assign sio_out  = sio_out_q;
  assign sio_oe   = oe_q & ~mem_ce;
  assign qpi_mode = qpi_q;
  assign cmd_err  = err_q;

endmodule
